// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter_pkg
// Brief  : Shared state encoding and constants for the two-master bus arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] c_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [7:0]  c_ERR_COUNT_MAX     = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module : bus_watchdog
// Brief  : Cycle counter that flags expiry after TIMEOUT enabled cycles.
// Rev    : 1.0  initial release
// ============================================================================
module bus_watchdog #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam logic [TIMEOUT_W-1:0] c_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Round-robin two-master arbiter with watchdog error completion.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter int          TIMEOUT_W = 8,
    parameter logic [31:0] ERR_RDATA = c_ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        err_irq,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_last_grant;
    logic        w_last_grant_next;
    logic [31:0] r_err_addr;
    logic [7:0]  r_err_count;

    logic        w_granted;
    logic        w_sel;
    logic        w_req_valid;
    logic        w_expire;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    bus_watchdog #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (r_state == ST_IDLE),
        .i_count_en (w_granted & ~s_ready),
        .o_expire   (w_expire)
    );

    // Master mux and response steering, decoded from the registered grant.
    always_comb begin
        w_granted   = (r_state != ST_IDLE);
        w_sel       = (r_state == ST_GRANT1);
        w_req_valid = w_sel ? m1_valid : m0_valid;
        s_valid     = w_granted & w_req_valid;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        if (w_granted) begin
            s_addr  = w_sel ? m1_addr  : m0_addr;
            s_wdata = w_sel ? m1_wdata : m0_wdata;
        end
        if (s_valid) begin
            s_wstrb = w_sel ? m1_wstrb : m0_wstrb;
        end
        w_timeout = s_valid & ~s_ready & w_expire;
        w_done    = (s_valid & s_ready) | w_timeout;
        w_rdata   = w_timeout ? ERR_RDATA : s_rdata;
        m0_ready  = (r_state == ST_GRANT0) & w_done;
        m1_ready  = (r_state == ST_GRANT1) & w_done;
        m0_rdata  = (r_state == ST_GRANT0) ? w_rdata : '0;
        m1_rdata  = (r_state == ST_GRANT1) ? w_rdata : '0;
        err_irq   = w_timeout;
    end

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (m0_valid && m1_valid) begin
                    w_state_next = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (m0_valid) begin
                    w_state_next = ST_GRANT0;
                end else if (m1_valid) begin
                    w_state_next = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                // A master abandoning its request forfeits the grant silently.
                if (!w_req_valid) begin
                    w_state_next = ST_IDLE;
                end else if (w_done) begin
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = w_sel;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_err_addr   <= '0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            if (w_timeout) begin
                r_err_addr <= s_addr;
                if (r_err_count != c_ERR_COUNT_MAX) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Scoreboard bench for mem_arbiter with an address-driven slave model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        err_irq;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .err_irq(err_irq), .err_addr(err_addr), .err_count(err_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          done_log[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_err_cnt = 0;
    logic [31:0] exp_err_addr = '0;
    bit          chk_err = 1'b0;

    // Slave map: region 3 never answers, region 4 answers on wait 254, else small wait.
    function automatic int slave_lat(input logic [31:0] a);
        case (a[27:24])
            4'h3:    return -1;
            4'h4:    return 254;
            default: return int'(a[4:2] ^ 3'd1);
        endcase
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rand_addr(input bit hang);
        logic [31:0] r;
        r = $urandom;
        return {4'h0, (hang ? 4'h3 : 4'h1), r[23:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_master(input int n, input logic v, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] ws);
        if (n == 0) begin
            m0_valid = v; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end else begin
            m1_valid = v; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] ws);
        exp_t e;
        e.addr  = a;
        e.wdata = wd;
        e.wstrb = ws;
        e.err   = (slave_lat(a) < 0);
        e.rdata = e.err ? 32'hDEAD_BEEF : slave_data(a);
        return e;
    endfunction

    task automatic push_exp(input int n, input exp_t e);
        if (n == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One complete transfer; cyc = negedges from request to ready.
    task automatic do_xfer(input int n, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, output int cyc);
        bit got;
        push_exp(n, make_exp(a, wd, ws));
        @(posedge clk); #1;
        set_master(n, 1'b1, a, wd, ws);
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 1000 && !got; i++) begin
            @(negedge clk);
            if ((n == 0) ? m0_ready : m1_ready) begin
                got = 1'b1;
                cyc = i;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL xfer_wait m%0d: got no ready expected ready within 1000 cycles", n);
        end
        @(posedge clk); #1;
        set_master(n, 1'b0, '0, '0, '0);
    endtask

    always @(posedge clk) begin : slave_model
        int lat;
        int s_cnt;
        bit s_act;
        #2;
        if (reset || !s_valid) begin
            s_act   = 1'b0;
            s_cnt   = 0;
            s_ready = 1'b0;
            s_rdata = $urandom;
        end else begin
            if (!s_act) begin
                s_act = 1'b1;
                s_cnt = 0;
            end else begin
                s_cnt++;
            end
            lat     = slave_lat(s_addr);
            s_ready = (lat >= 0) && (s_cnt == lat);
            s_rdata = s_ready ? slave_data(s_addr) : $urandom;
        end
    end

    task automatic mon_done(input int n);
        exp_t e;
        if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_ready m%0d: got ready expected none", n);
            return;
        end
        e = (n == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rdata m%0d", n), (n == 0) ? m0_rdata : m1_rdata, e.rdata);
        check($sformatf("other_rdata m%0d", n), (n == 0) ? m1_rdata : m0_rdata, 32'h0);
        check($sformatf("err_irq m%0d", n), {31'b0, err_irq}, {31'b0, e.err});
        check($sformatf("s_addr m%0d", n), s_addr, e.addr);
        check($sformatf("s_wdata m%0d", n), s_wdata, e.wdata);
        check($sformatf("s_wstrb m%0d", n), {28'b0, s_wstrb}, {28'b0, e.wstrb});
        if (e.err) begin
            if (exp_err_cnt < 255) exp_err_cnt++;
            exp_err_addr = e.addr;
            chk_err      = 1'b1;
        end
        done_log.push_back(n);
    endtask

    always @(negedge clk) begin : monitor
        if (reset) begin
            exp_err_cnt = 0;
            chk_err     = 1'b0;
        end else begin
            if (chk_err) begin
                check("err_addr", err_addr, exp_err_addr);
                check("err_count", {24'b0, err_count}, 32'(exp_err_cnt));
                chk_err = 1'b0;
            end
            if (!s_valid) check("s_wstrb_idle", {28'b0, s_wstrb}, 32'h0);
            if (m0_ready && m1_ready) begin
                n_cmp++;
                n_fail++;
                $display("FAIL dual_ready: got both readies expected at most one");
            end else if (m0_ready) begin
                mon_done(0);
            end else if (m1_ready) begin
                mon_done(1);
            end else if (err_irq) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_irq: got err_irq=1 expected 0 without ready");
            end
        end
    end

    initial begin : time_limit
        #500000;
        $display("FAIL time_limit: got no finish expected finish before 50000 cycles");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        int  cyc;
        bit  got;
        logic [31:0] a1;

        repeat (3) @(posedge clk);
        #1;
        check("rst s_valid", {31'b0, s_valid}, 32'h0);
        check("rst m0_ready", {31'b0, m0_ready}, 32'h0);
        check("rst m1_rdata", m1_rdata, 32'h0);
        check("rst err_irq", {31'b0, err_irq}, 32'h0);
        check("rst err_count", {24'b0, err_count}, 32'h0);
        check("rst err_addr", err_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        do_xfer(0, 32'h0000_0100, 32'h0, 4'h0, cyc);
        check("t1 latency", 32'(cyc), 32'd3);

        @(posedge clk); #1;
        set_master(0, 1'b1, 32'h0300_0010, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("t5 granted", {31'b0, s_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("t5 s_valid", {31'b0, s_valid}, 32'h0);
        check("t5 m0_ready", {31'b0, m0_ready}, 32'h0);
        set_master(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        reset = 1'b0;

        done_log.delete();
        fork
            begin
                int c0;
                for (int i = 0; i < 4; i++)
                    do_xfer(0, rand_addr(1'b0), $urandom, 4'($urandom_range(0, 15)), c0);
            end
            begin
                int c1;
                for (int i = 0; i < 4; i++)
                    do_xfer(1, rand_addr(1'b0), $urandom, 4'($urandom_range(0, 15)), c1);
            end
        join
        check("t2 log size", 32'(done_log.size()), 32'd8);
        for (int i = 0; i < done_log.size(); i++)
            check($sformatf("t2 order %0d", i), 32'(done_log[i]), 32'(i % 2));

        a1 = 32'h0100_0024;
        push_exp(1, make_exp(a1, 32'h5555_AAAA, 4'h3));
        @(posedge clk); #1;
        set_master(0, 1'b1, 32'h0300_0040, 32'h0, 4'h0);
        set_master(1, 1'b1, a1, 32'h5555_AAAA, 4'h3);
        repeat (3) @(negedge clk);
        check("t6 m0 granted", s_addr, 32'h0300_0040);
        @(posedge clk); #1;
        set_master(0, 1'b0, '0, '0, '0);
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (s_valid) got = 1'b1;
        end
        check("t6 m1 granted next", s_addr, a1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (m1_ready) got = 1'b1;
            else @(negedge clk);
        end
        check("t6 m1 ready", {31'b0, got}, 32'h1);
        @(posedge clk); #1;
        set_master(1, 1'b0, '0, '0, '0);

        do_xfer(1, 32'h0300_0000, 32'hCAFE_F00D, 4'hF, cyc);
        check("t3 timeout cycle", 32'(cyc), 32'd256);
        do_xfer(0, 32'h0400_0000, 32'h0, 4'h0, cyc);
        check("t4 late ready cycle", 32'(cyc), 32'd256);
        @(negedge clk);
        check("t4 err_count kept", {24'b0, err_count}, 32'd1);

        fork
            begin
                int c0;
                for (int i = 0; i < 30; i++) begin
                    do_xfer(0, rand_addr($urandom_range(0, 15) == 0), $urandom,
                            4'($urandom_range(0, 15)), c0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                int c1;
                for (int i = 0; i < 30; i++) begin
                    do_xfer(1, rand_addr($urandom_range(0, 15) == 0), $urandom,
                            4'($urandom_range(0, 15)), c1);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
